// File: rtl/cla_pkg.sv
// cla_pkg: q-pair bit indices and the generate/propagate combine shared by both lookahead levels
package cla_pkg;
    localparam int Q_G = 1;
    localparam int Q_P = 0;

    function automatic logic [1:0] q_combine(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[Q_G] | (hi[Q_P] & lo[Q_G]), hi[Q_P] & lo[Q_P]};
    endfunction
endpackage

// File: rtl/cla_group_qg.sv
// cla_group_qg: folds per-bit q pairs of one lookahead group into the group (G, P) pair
module cla_group_qg
    import cla_pkg::*;
#(
    parameter int GROUPSIZE = 8
) (
    input  logic [2*GROUPSIZE-1:0] q,
    output logic [1:0]             qg
);
    always_comb begin
        qg = q[1:0];
        for (int i = 1; i < GROUPSIZE; i++) qg = q_combine(q[2*i +: 2], qg);
    end
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: two-stage carry-lookahead adder/subtractor with valid/ready flow control
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NGROUPS = WIDTH / GROUPSIZE;

    if ((GROUPSIZE != 1 && GROUPSIZE != 2 && GROUPSIZE != 4 && GROUPSIZE != 8 && GROUPSIZE != 16)
        || (WIDTH % GROUPSIZE != 0)) begin : g_bad_cfg
        $error("pipelined_cla_adder: GROUPSIZE must be 1,2,4,8,16 and divide WIDTH");
    end

    logic [WIDTH-1:0]     b_eff, sum_n;
    logic [2*WIDTH-1:0]   q_in, s1_q;
    logic [2*NGROUPS-1:0] qg_in, s1_qg;
    logic [NGROUPS-1:0]   c_grp;
    logic                 s1_cin, s1_valid, s2_valid, s1_load, s2_load;
    logic                 cr, c_msb, cout_n, ovf_n;

    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign b_eff     = sub ? ~b : b;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            q_in[2*i+Q_G] = a[i] & b_eff[i];
            q_in[2*i+Q_P] = a[i] ^ b_eff[i];
        end
    end

    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        cla_group_qg #(.GROUPSIZE(GROUPSIZE)) u_qg (
            .q (q_in[2*GROUPSIZE*k +: 2*GROUPSIZE]),
            .qg(qg_in[2*k +: 2])
        );
    end

    // Group carries come from the lookahead chain; each group then ripples internally from its own c_grp.
    always_comb begin
        cr = s1_cin;
        for (int k = 0; k < NGROUPS; k++) begin
            c_grp[k] = cr;
            cr = s1_qg[2*k+Q_G] | (s1_qg[2*k+Q_P] & cr);
        end
        sum_n = '0;
        c_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cr = (i % GROUPSIZE == 0) ? c_grp[i/GROUPSIZE] : cr;
            sum_n[i] = s1_q[2*i+Q_P] ^ cr;
            c_msb = (i == WIDTH-1) ? cr : c_msb;
            cr = s1_q[2*i+Q_G] | (s1_q[2*i+Q_P] & cr);
        end
        cout_n = cr;
        ovf_n  = cr ^ c_msb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s1_qg    <= '0;
            s1_cin   <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            s1_valid <= s1_load | (s1_valid & ~s2_load);
            s2_valid <= s2_load | (s2_valid & ~out_ready);
            if (s1_load) begin
                s1_q   <= q_in;
                s1_qg  <= qg_in;
                s1_cin <= sub ? ~cin : cin;
            end
            if (s2_load) begin
                sum  <= sum_n;
                cout <= cout_n;
                ovf  <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and random checks of the pipelined adder across all group sizes
module tb_pipelined_cla_adder;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready_g [5];
    logic        out_valid_g [5];
    logic        cout_g [5];
    logic        ovf_g [5];
    logic [31:0] sum_g [5];
    logic        in_ready, out_valid, cout, ovf;
    logic [31:0] sum;
    int          checks = 0, errors = 0, acc = 0, outs = 0, acc0, outs0;
    logic [33:0] exp_q [$];
    logic        held_v = 1'b0;
    logic [33:0] held = '0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 5; k++) begin : g_dut
        pipelined_cla_adder #(.WIDTH(32), .GROUPSIZE(1 << k)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_g[k]),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(out_valid_g[k]), .out_ready(out_ready),
            .sum(sum_g[k]), .cout(cout_g[k]), .ovf(ovf_g[k])
        );
    end

    assign in_ready  = in_ready_g[3];
    assign out_valid = out_valid_g[3];
    assign sum       = sum_g[3];
    assign cout      = cout_g[3];
    assign ovf       = ovf_g[3];

    // Reference result {cout, ovf, sum} from plain integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      c  = longint'({31'b0, ci});
        longint      r  = s ? sx - sy - c : sx + sy + c;
        logic [32:0] u  = s ? {1'b0, x} - {1'b0, y} - {32'b0, ci} : {1'b0, x} + {1'b0, y} + {32'b0, ci};
        logic        co = s ? ~u[32] : u[32];
        logic        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {co, ov, u[31:0]};
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (held_v && out_valid) chk("stall_hold", {30'b0, cout, ovf, sum}, {30'b0, held});
        held_v = out_valid && !out_ready;
        held   = {cout, ovf, sum};
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc++;
        end
        if (out_valid && out_ready) begin
            outs++;
            if (exp_q.size() == 0) chk("unexpected_out", {63'b0, out_valid}, 64'd0);
            else begin
                for (int k = 0; k < 5; k++) begin
                    chk($sformatf("result_gs%0d", 1 << k), {30'b0, cout_g[k], ovf_g[k], sum_g[k]}, {30'b0, exp_q[0]});
                    chk($sformatf("valid_gs%0d", 1 << k), {63'b0, out_valid_g[k]}, 64'd1);
                end
                void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        chk("op_in_ready", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", {30'b0, cout, ovf, sum}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_cycle1", {63'b0, out_valid}, 64'd0);
        tick();
        chk("lat_cycle2", {63'b0, out_valid}, 64'd1);
        chk("wrap_result", {30'b0, cout, ovf, sum}, {30'b0, 1'b1, 1'b0, 32'h0});
        repeat (2) tick();

        op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        op(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        op(32'h5, 32'h7, 1'b0, 1'b1);
        op(32'h7, 32'h5, 1'b1, 1'b1);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

        outs0 = outs;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            chk("b2b_in_ready", {63'b0, in_ready}, 64'd1);
            tick();
            if (n >= 1) chk("b2b_out_valid", {63'b0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("b2b_count", 64'(outs - outs0), 64'd16);

        acc0 = acc; outs0 = outs;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            tick();
        end
        chk("stall_accepted", 64'(acc - acc0), 64'd2);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("stall_released", 64'(outs - outs0), 64'd2);
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            a = rnd(); b = rnd(); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_full", {62'b0, out_valid, in_ready}, {62'b0, 1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_result", {30'b0, cout, ovf, sum}, 64'd0);
        exp_q.delete();
        held_v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        chk("final_drain", 64'(exp_q.size()), 64'd0);
        chk("final_out_valid", {63'b0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
